// File: rtl/bcd_disp_pkg.sv
// Shared types and default constants for the BCD display scan logic.
//   scan_state_t : scan controller states (S_OFF, S_ON, S_GAP)
//   bcd_t        : one BCD digit nibble
//   DEF_*        : default NUM_DIGITS / SCAN_DIV / GAP_CYC values
package bcd_disp_pkg;

    typedef enum logic [1:0] {
        S_OFF = 2'd0,
        S_ON  = 2'd1,
        S_GAP = 2'd2
    } scan_state_t;

    typedef logic [3:0] bcd_t;

    localparam int unsigned DEF_NUM_DIGITS = 4;
    localparam int unsigned DEF_SCAN_DIV   = 50000;
    localparam int unsigned DEF_GAP_CYC    = 500;

endpackage

// File: rtl/bcd_scan_timer.sv
// Digit slot timer. Counts clock cycles within one digit slot while run is high and
// flags the last lit cycle and the last cycle of the slot.
//   clk       : system clock
//   rst_n     : synchronous active-low reset
//   run       : count enable; low holds the counter at zero
//   gap_start : counter is at SCAN_DIV-GAP_CYC-1 (last lit cycle of the slot)
//   slot_end  : counter is at SCAN_DIV-1 (last cycle of the slot)
module bcd_scan_timer
    import bcd_disp_pkg::*;
#(
    parameter int unsigned SCAN_DIV = DEF_SCAN_DIV,
    parameter int unsigned GAP_CYC  = DEF_GAP_CYC
) (
    input  logic clk,
    input  logic rst_n,
    input  logic run,
    output logic gap_start,
    output logic slot_end
);

    localparam int unsigned CntW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [CntW-1:0] GapAt = CntW'(SCAN_DIV - GAP_CYC - 1);
    localparam logic [CntW-1:0] EndAt = CntW'(SCAN_DIV - 1);

    logic [CntW-1:0] cnt_q, cnt_d;

    assign gap_start = (cnt_q == GapAt);
    assign slot_end  = (cnt_q == EndAt);

    always_comb begin
        cnt_d = cnt_q;
        if (!run || slot_end) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/bcd_scan_mux.sv
// Time-multiplexed scan controller for a common-anode multi-digit 7-segment display.
// Holds a double-buffered digit set, presents one nibble at a time to the decoder,
// drives the matching active-low anode and blanks all anodes at the end of each slot.
//   clk      : system clock
//   rst_n    : synchronous active-low reset
//   en       : scan enable; low forces the display off
//   load     : capture strobe for digits_i
//   digits_i : BCD digits, digit k at [4k+3:4k], k=0 least significant
//   digit_o  : current digit nibble to the 7-seg decoder
//   an_o     : active-low anode enables, at most one low
//   blank_o  : high when no anode is driven
//   frame_o  : one-cycle pulse in the first cycle of each new frame
// Optional: define BCD_SCAN_LZB_EN for leading-zero blanking (digit 0 is always lit).
module bcd_scan_mux
    import bcd_disp_pkg::*;
#(
    parameter int unsigned NUM_DIGITS = DEF_NUM_DIGITS,
    parameter int unsigned SCAN_DIV   = DEF_SCAN_DIV,
    parameter int unsigned GAP_CYC    = DEF_GAP_CYC
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    en,
    input  logic                    load,
    input  logic [4*NUM_DIGITS-1:0] digits_i,
    output logic [3:0]              digit_o,
    output logic [NUM_DIGITS-1:0]   an_o,
    output logic                    blank_o,
    output logic                    frame_o
);

    localparam int unsigned IdxW = $clog2(NUM_DIGITS);
    localparam logic [IdxW-1:0] LastIdx = IdxW'(NUM_DIGITS - 1);

    scan_state_t               state_q, state_d;
    logic [IdxW-1:0]           idx_q, idx_d;
    logic [4*NUM_DIGITS-1:0]   active_q, active_d;
    logic [4*NUM_DIGITS-1:0]   pending_q, pending_d;
    logic                      pending_valid_q, pending_valid_d;
    logic                      frame_q, frame_d;
    logic                      run;
    logic                      gap_start;
    logic                      slot_end;
    logic                      show;
    bcd_t                      cur_digit;

    assign run = en && (state_q != S_OFF);

    bcd_scan_timer #(
        .SCAN_DIV (SCAN_DIV),
        .GAP_CYC  (GAP_CYC)
    ) u_timer (
        .clk       (clk),
        .rst_n     (rst_n),
        .run       (run),
        .gap_start (gap_start),
        .slot_end  (slot_end)
    );

    always_comb begin
        state_d         = state_q;
        idx_d           = idx_q;
        active_d        = active_q;
        pending_d       = pending_q;
        pending_valid_d = pending_valid_q;
        frame_d         = 1'b0;
        unique case (state_q)
            S_OFF: begin
                // Nothing is on screen, so a load can go straight to the display buffer.
                if (load) begin
                    active_d        = digits_i;
                    pending_valid_d = 1'b0;
                end
                if (en) begin
                    state_d = S_ON;
                    idx_d   = '0;
                end
            end
            S_ON, S_GAP: begin
                if (load) begin
                    pending_d       = digits_i;
                    pending_valid_d = 1'b1;
                end
                if (!en) begin
                    state_d = S_OFF;
                    idx_d   = '0;
                end else if (slot_end) begin
                    // Reached from S_ON only when GAP_CYC is zero.
                    state_d = S_ON;
                    if (idx_q == LastIdx) begin
                        idx_d   = '0;
                        frame_d = 1'b1;
                        // Commit uses the old pending value; a coincident load stays pending.
                        if (pending_valid_q) begin
                            active_d = pending_q;
                            if (!load) begin
                                pending_valid_d = 1'b0;
                            end
                        end
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end else if (state_q == S_ON && gap_start) begin
                    state_d = S_GAP;
                end
            end
            default: begin
                state_d = S_OFF;
                idx_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q         <= S_OFF;
            idx_q           <= '0;
            active_q        <= '0;
            pending_q       <= '0;
            pending_valid_q <= 1'b0;
            frame_q         <= 1'b0;
        end else begin
            state_q         <= state_d;
            idx_q           <= idx_d;
            active_q        <= active_d;
            pending_q       <= pending_d;
            pending_valid_q <= pending_valid_d;
            frame_q         <= frame_d;
        end
    end

`ifdef BCD_SCAN_LZB_EN
    // lead_zero[k]: digit k and every digit above it are zero.
    logic [NUM_DIGITS-1:0] lead_zero;
    always_comb begin
        logic zero_above;
        zero_above = 1'b1;
        lead_zero  = '0;
        for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
            zero_above   = zero_above && (active_q[4*k +: 4] == 4'd0);
            lead_zero[k] = zero_above;
        end
    end
    assign show = !((idx_q != '0) && lead_zero[idx_q]);
`else
    assign show = 1'b1;
`endif

    assign cur_digit = active_q[{idx_q, 2'b00} +: 4];

    always_comb begin
        an_o    = '1;
        blank_o = 1'b1;
        digit_o = 4'd0;
        if (state_q != S_OFF) begin
            digit_o = cur_digit;
        end
        if (state_q == S_ON && show) begin
            an_o[idx_q] = 1'b0;
            blank_o     = 1'b0;
        end
    end

    assign frame_o = frame_q;

endmodule

// File: tb/tb_bcd_scan_mux.sv
module tb_bcd_scan_mux;

    localparam int ND = 4;
    localparam int SD = 8;
    localparam int GC = 2;
    localparam int FR = ND * SD;

    logic        clk;
    logic        rst_n;
    logic        en;
    logic        load;
    logic [15:0] digits;
    logic [3:0]  digit_o;
    logic [3:0]  an_o;
    logic        blank_o;
    logic        frame_o;

    int total = 0;
    int bad   = 0;

    bcd_scan_mux #(
        .NUM_DIGITS (ND),
        .SCAN_DIV   (SD),
        .GAP_CYC    (GC)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (en),
        .load     (load),
        .digits_i (digits),
        .digit_o  (digit_o),
        .an_o     (an_o),
        .blank_o  (blank_o),
        .frame_o  (frame_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: position within the frame as a plain cycle count since scanning began.
    logic        m_on     = 1'b0;
    int          m_t      = 0;
    logic [15:0] m_active = '0;
    logic [15:0] m_pend   = '0;
    logic        m_pv     = 1'b0;
    logic        m_frame  = 1'b0;

    always @(posedge clk) begin
        if (!rst_n) begin
            m_on <= 1'b0; m_t <= 0; m_active <= '0; m_pend <= '0; m_pv <= 1'b0; m_frame <= 1'b0;
        end else begin
            m_frame <= 1'b0;
            if (!m_on) begin
                if (load) begin m_active <= digits; m_pv <= 1'b0; end
                if (en) begin m_on <= 1'b1; m_t <= 0; end
            end else if (!en) begin
                if (load) begin m_pend <= digits; m_pv <= 1'b1; end
                m_on <= 1'b0;
                m_t  <= 0;
            end else begin
                m_t <= (m_t + 1) % FR;
                if ((m_t + 1) % FR == 0) begin
                    m_frame <= 1'b1;
                    if (m_pv) begin m_active <= m_pend; m_pv <= 1'b0; end
                end
                // Later nonblocking writes win, so a coincident load re-arms pending.
                if (load) begin m_pend <= digits; m_pv <= 1'b1; end
            end
        end
    end

    int         slot;
    int         ph;
    logic       lit;
    logic [3:0] exp_an;

    always @(negedge clk) begin
        slot   = m_t / SD;
        ph     = m_t % SD;
        exp_an = 4'hF;
        if (m_on) begin
            lit = (ph < SD - GC);
`ifdef BCD_SCAN_LZB_EN
            if (slot > 0 && (m_active >> (4 * slot)) == 16'd0) lit = 1'b0;
`endif
            if (lit) exp_an[slot] = 1'b0;
            chk("mdl_digit", {12'd0, digit_o}, {12'd0, m_active[slot*4 +: 4]});
        end else begin
            lit = 1'b0;
        end
        chk("mdl_an", {12'd0, an_o}, {12'd0, exp_an});
        chk("mdl_blank", {15'd0, blank_o}, {15'd0, ~lit});
        chk("mdl_frame", {15'd0, frame_o}, {15'd0, m_frame});
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic ticks(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_an"}, {12'd0, an_o}, 16'h000F);
        chk({tag, "_digit"}, {12'd0, digit_o}, 16'h0000);
        chk({tag, "_blank"}, {15'd0, blank_o}, 16'h0001);
        chk({tag, "_frame"}, {15'd0, frame_o}, 16'h0000);
    endtask

    initial begin
        rst_n = 1'b0; en = 1'b1; load = 1'b0; digits = '0;
        ticks(3);
        chk_reset("rst");
        rst_n = 1'b1;
        tick();
        chk("rel_an", {12'd0, an_o}, 16'h000E);

        // Load while off, then scan 1234.
        en = 1'b0;
        tick();
        chk("off_an", {12'd0, an_o}, 16'h000F);
        load = 1'b1; digits = 16'h1234;
        tick();
        load = 1'b0; en = 1'b1;
        tick();                                          // cycle 0
        chk("c0_an", {12'd0, an_o}, 16'h000E);
        chk("c0_digit", {12'd0, digit_o}, 16'h0004);
        ticks(6);                                        // cycle 6: gap
        chk("c6_an", {12'd0, an_o}, 16'h000F);
        chk("c6_blank", {15'd0, blank_o}, 16'h0001);
        ticks(2);                                        // cycle 8
        chk("c8_an", {12'd0, an_o}, 16'h000D);
        chk("c8_digit", {12'd0, digit_o}, 16'h0003);
        load = 1'b1; digits = 16'h5678;
        tick();                                          // cycle 9
        load = 1'b0;
        ticks(7);                                        // cycle 16: no tearing
        chk("c16_an", {12'd0, an_o}, 16'h000B);
        chk("c16_digit", {12'd0, digit_o}, 16'h0002);
        ticks(8);                                        // cycle 24
        chk("c24_an", {12'd0, an_o}, 16'h0007);
        chk("c24_digit", {12'd0, digit_o}, 16'h0001);
        ticks(7);                                        // cycle 31
        chk("c31_frame", {15'd0, frame_o}, 16'h0000);
        tick();                                          // cycle 32: new frame
        chk("c32_frame", {15'd0, frame_o}, 16'h0001);
        chk("c32_digit", {12'd0, digit_o}, 16'h0008);
        tick();
        chk("c33_frame", {15'd0, frame_o}, 16'h0000);
        ticks(7);                                        // cycle 40
        chk("c40_digit", {12'd0, digit_o}, 16'h0007);

        // Drop en in cycle 3 of the digit-2 slot.
        ticks(43);                                       // cycle 83
        en = 1'b0;
        tick();
        chk("drop_an", {12'd0, an_o}, 16'h000F);
        chk("drop_blank", {15'd0, blank_o}, 16'h0001);
        en = 1'b1;
        tick();
        chk("re_an", {12'd0, an_o}, 16'h000E);
        chk("re_digit", {12'd0, digit_o}, 16'h0008);
        ticks(5);
        chk("re5_an", {12'd0, an_o}, 16'h000E);
        tick();
        chk("re6_an", {12'd0, an_o}, 16'h000F);

        // Reset pulse mid-scan.
        ticks(4);
        rst_n = 1'b0;
        tick();
        chk_reset("mid");
        rst_n = 1'b1;
        tick();                                          // cycle 0
        chk("mid_rel_an", {12'd0, an_o}, 16'h000E);
        chk("mid_rel_digit", {12'd0, digit_o}, 16'h0000);

        // Load coincident with a frame commit; nibbles A-F pass through.
        load = 1'b1; digits = 16'h1234;
        tick();                                          // cycle 1
        load = 1'b0;
        ticks(31);                                       // cycle 32
        chk("k32_digit", {12'd0, digit_o}, 16'h0004);
        ticks(8);                                        // cycle 40
        load = 1'b1; digits = 16'h4321;
        tick();
        load = 1'b0;
        ticks(22);                                       // cycle 63: last cycle of frame
        load = 1'b1; digits = 16'hFACE;
        tick();                                          // cycle 64
        load = 1'b0;
        chk("k64_frame", {15'd0, frame_o}, 16'h0001);
        chk("k64_digit", {12'd0, digit_o}, 16'h0001);
        ticks(8);
        chk("k72_digit", {12'd0, digit_o}, 16'h0002);
        ticks(24);                                       // cycle 96
        chk("k96_digit", {12'd0, digit_o}, 16'h000E);
        ticks(8);
        chk("k104_digit", {12'd0, digit_o}, 16'h000C);
        ticks(8);
        chk("k112_digit", {12'd0, digit_o}, 16'h000A);
        ticks(8);
        chk("k120_digit", {12'd0, digit_o}, 16'h000F);
        chk("k120_an", {12'd0, an_o}, 16'h0007);

        // All-zero value: every slot lights unless leading-zero blanking is built in.
        en = 1'b0;
        tick();
        load = 1'b1; digits = 16'h0000;
        tick();
        load = 1'b0; en = 1'b1;
        tick();
        chk("z0_an", {12'd0, an_o}, 16'h000E);
        chk("z0_digit", {12'd0, digit_o}, 16'h0000);
        ticks(16);
`ifdef BCD_SCAN_LZB_EN
        chk("z16_an", {12'd0, an_o}, 16'h000F);
`else
        chk("z16_an", {12'd0, an_o}, 16'h000B);
`endif
        ticks(8);
`ifdef BCD_SCAN_LZB_EN
        chk("z24_an", {12'd0, an_o}, 16'h000F);
`else
        chk("z24_an", {12'd0, an_o}, 16'h0007);
`endif
        ticks(2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/bcd_scan_mux.md
Name: bcd_scan_mux

Overview:
Time-multiplexed scan controller for a common-anode multi-digit 7-segment display. Sits directly upstream of the BCD-to-7-segment decoder.
- Holds a double-buffered set of BCD digits.
- Presents one digit nibble at a time on digit_o, which feeds the decoder input.
- Drives the matching active-low anode enable.
- Inserts an anti-ghosting blank gap between digits.

Parameters:
NUM_DIGITS, 4, number of display digits (2..8)
SCAN_DIV, 50000, clock cycles per digit slot (>=2)
GAP_CYC, 500, cycles at end of each slot with all anodes off (0 <= GAP_CYC < SCAN_DIV)

Ports:
clk  input  1  system clock; all logic on rising edge
rst_n  input  1  synchronous, active-low reset
en  input  1  scan enable; low forces display off
load  input  1  capture strobe for digits_i
digits_i  input  4*NUM_DIGITS  BCD digits; digit k at [4k+3:4k], k=0 is least significant
digit_o  output  4  current digit nibble to the 7-seg decoder
an_o  output  NUM_DIGITS  anode enables, active-low, at most one low
blank_o  output  1  high when no anode is driven
frame_o  output  1  one-cycle pulse at frame wrap

Behaviour:
- Clock and reset: single clock clk. Reset rst_n is synchronous and active-low.
- Reset values: state=S_OFF, idx=0, cnt=0, active=0, pending=0, pending_valid=0, an_o=all 1, digit_o=0, blank_o=1, frame_o=0.
- Output timing: Moore outputs, decoded from registered state/idx/active. They change on the edge that updates state, with no extra latency.
- FSM states:
  - S_OFF: all anodes off. If en=1, next state is S_ON with idx=0, cnt=0.
  - S_ON: an_o[idx]=0, digit_o=active[idx], blank_o=0. cnt increments each cycle. When cnt==SCAN_DIV-GAP_CYC-1, next state is S_GAP (cnt still increments). If GAP_CYC=0, go straight to the slot-end action.
  - S_GAP: an_o all 1, blank_o=1, digit_o holds. When cnt==SCAN_DIV-1: cnt=0, next state is S_ON.
    - If idx<NUM_DIGITS-1: idx=idx+1.
    - Else: idx=0 and frame_o=1 for exactly one cycle (registered, asserted during the first cycle of the new frame). If pending_valid, then active<=pending and pending_valid<=0.
- en=0 in S_ON or S_GAP: next state S_OFF, idx=0, cnt=0. A later en=1 restarts at digit 0.
- Load handling:
  - load=1 in S_ON/S_GAP: pending<=digits_i, pending_valid<=1. The displayed frame never tears.
  - load=1 in S_OFF: active<=digits_i directly; pending_valid<=0.
  - load coincident with a frame commit: the commit uses the old pending value. The new value is captured into pending and pending_valid stays 1.
- Nibbles 10-15: passed through unchanged; the decoder defines their glyphs.
- Reset mid-operation: on the sampled rst_n=0 edge, all registers take their reset values regardless of state.

Optional Feature:
Macro BCD_SCAN_LZB_EN enables leading-zero blanking.
- Defined: during S_ON for idx>0, if active[idx] and all higher digits are 0, then an_o stays all 1 and blank_o=1. digit_o still carries the nibble and slot timing is unchanged. Digit 0 is always shown.
- Undefined: every digit is always shown.

Decomposition:
- Package bcd_disp_pkg:
  - state enum scan_state_t {S_OFF, S_ON, S_GAP}
  - default constants for NUM_DIGITS/SCAN_DIV/GAP_CYC
  - typedef bcd_t = logic [3:0]
- Sub-module bcd_scan_timer: slot counter cnt plus gap_start/slot_end strobes, parameterised by SCAN_DIV and GAP_CYC. FSM, buffering and output decode stay in the top.

Test Plan (NUM_DIGITS=4, SCAN_DIV=8, GAP_CYC=2):
1. rst_n=0 for 3 edges with en=1 -> an_o=1111, digit_o=0, blank_o=1, frame_o=0. On the first edge after release -> an_o=1110.
2. In S_OFF, load digits_i=16'h1234, then en=1 -> expected sequence, with frame_o high for 1 cycle at cycle 32:
   - an_o=1110 with digit_o=4 for 6 cycles, then 1111 for 2 cycles
   - 1101 with digit_o=3, then 1011 with digit_o=2, then 0111 with digit_o=1 (each 6 on / 2 gap)
3. During digit-1 slot of 16'h1234, load 16'h5678 -> digits 2,3 still show 2,1. Next frame shows 8,7,6,5, and pending_valid clears at the frame_o pulse.
4. Drop en in cycle 3 of digit-2 slot -> next edge an_o=1111, blank_o=1. Reassert en -> an_o=1110 with cnt restarted.
5. Pulse rst_n low for 1 edge mid-scan -> all reset values, including active=0. After release, with en=1, digit_o=0 on digit 0.
6. With BCD_SCAN_LZB_EN: 16'h0042 -> slots 2,3 keep an_o=1111. 16'h0000 -> only slot 0 lights, with digit_o=0. Without the macro, all four slots light.
